// File: rtl/ccsds123_frame_header.sv
// Prepends a self-describing header word (geometry, depth, prediction bands, frame
// sequence number) to every compressed frame and adds AXI-stream backpressure.
module ccsds123_frame_header #(
    parameter int BUS_WIDTH = 64,
    parameter int NX        = 16,
    parameter int NY        = 16,
    parameter int NZ        = 16,
    parameter int D         = 16,
    parameter int P         = 3
) (
    input  logic                 clk,
    input  logic                 areset,
    input  logic [BUS_WIDTH-1:0] in_tdata,
    input  logic                 in_tvalid,
    input  logic                 in_tlast,
    output logic                 in_tready,
    output logic [BUS_WIDTH-1:0] out_tdata,
    output logic                 out_tvalid,
    output logic                 out_tlast,
    output logic                 out_tuser,
    input  logic                 out_tready
);

    typedef enum logic {
        HDR,
        PAY
    } state_t;

    state_t               state;
    logic [6:0]           frame_cnt;
    logic                 load_en;
    logic [BUS_WIDTH-1:0] header;

    // The single output register may refill whenever it is empty or being drained.
    assign load_en = !out_tvalid || out_tready;

    // NOTE: in_tready is combinational so a drained output register can refill in the
    // same cycle; it stays low in HDR, which is the one-cycle header bubble per frame.
    assign in_tready = (state == PAY) && load_en;

    // NOTE: every variable written here gets a default first, so no latch is inferred.
    always_comb begin
        header         = '0;
        header[15:0]   = 16'(NX);
        header[31:16]  = 16'(NY);
        header[47:32]  = 16'(NZ);
        header[52:48]  = 5'(D - 1);
        header[56:53]  = 4'(P);
        header[63:57]  = frame_cnt;
    end

    // NOTE: sequential state uses non-blocking assignments only, so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            state      <= HDR;
            frame_cnt  <= '0;
            out_tdata  <= '0;
            out_tvalid <= 1'b0;
            out_tlast  <= 1'b0;
            out_tuser  <= 1'b0;
        end else if (load_en) begin
            // A drained word with nothing new behind it empties the register.
            out_tvalid <= 1'b0;
            case (state)
                HDR: begin
                    // The header waits until the frame's first payload word is pending.
                    if (in_tvalid) begin
                        out_tdata  <= header;
                        out_tvalid <= 1'b1;
                        out_tuser  <= 1'b1;
                        out_tlast  <= 1'b0;
                        state      <= PAY;
                    end
                end
                PAY: begin
                    if (in_tvalid) begin
                        out_tdata  <= in_tdata;
                        out_tvalid <= 1'b1;
                        out_tuser  <= 1'b0;
                        out_tlast  <= in_tlast;
                        if (in_tlast) begin
                            state     <= HDR;
                            frame_cnt <= frame_cnt + 7'd1;
                        end
                    end
                end
                default: state <= HDR;
            endcase
        end
    end

endmodule

// File: tb/tb_ccsds123_frame_header.sv
// Randomized bench for ccsds123_frame_header: a frame-level reference model builds
// the expected output stream (header + payload per frame) and a scoreboard compares it.
module tb_ccsds123_frame_header;

    localparam int BW   = 64;
    localparam int NX_T = 4;
    localparam int NY_T = 4;
    localparam int NZ_T = 2;
    localparam int D_T  = 16;
    localparam int P_T  = 3;

    logic          clk = 1'b0;
    logic          areset;
    logic [BW-1:0] in_tdata;
    logic          in_tvalid;
    logic          in_tlast;
    logic          in_tready;
    logic [BW-1:0] out_tdata;
    logic          out_tvalid;
    logic          out_tlast;
    logic          out_tuser;
    logic          out_tready;

    ccsds123_frame_header #(
        .BUS_WIDTH(BW), .NX(NX_T), .NY(NY_T), .NZ(NZ_T), .D(D_T), .P(P_T)
    ) dut (
        .clk        (clk),
        .areset     (areset),
        .in_tdata   (in_tdata),
        .in_tvalid  (in_tvalid),
        .in_tlast   (in_tlast),
        .in_tready  (in_tready),
        .out_tdata  (out_tdata),
        .out_tvalid (out_tvalid),
        .out_tlast  (out_tlast),
        .out_tuser  (out_tuser),
        .out_tready (out_tready)
    );

    always #5 clk = ~clk;

    int tests_run = 0;
    int tests_failed = 0;

    // Reference model state: source words still to send, expected output stream.
    logic [BW-1:0] src_d[$];
    bit            src_l[$];
    logic [BW-1:0] exp_d[$];
    bit            exp_u[$];
    bit            exp_l[$];
    int            model_cnt;

    // Observations from the latest run.
    logic [BW-1:0] hdr_seen[$];
    int            out_cyc[$];
    bit            rdy_trace[$];
    int            first_in_cyc;
    int            cyc;

    task automatic check(input string tag, input logic [BW-1:0] got, input logic [BW-1:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [BW-1:0] model_hdr(input int cnt);
        return (64'(cnt % 128) << 57) | (64'(P_T) << 53) | (64'(D_T - 1) << 48)
             | (64'(NZ_T) << 32) | (64'(NY_T) << 16) | 64'(NX_T);
    endfunction

    task automatic add_frame(input int len);
        logic [BW-1:0] w;
        exp_d.push_back(model_hdr(model_cnt));
        exp_u.push_back(1'b1);
        exp_l.push_back(1'b0);
        for (int i = 0; i < len; i++) begin
            w = {$urandom, $urandom};
            src_d.push_back(w);
            src_l.push_back(i == len - 1);
            exp_d.push_back(w);
            exp_u.push_back(1'b0);
            exp_l.push_back(i == len - 1);
        end
        model_cnt = (model_cnt + 1) % 128;
    endtask

    task automatic clear_model();
        src_d.delete(); src_l.delete();
        exp_d.delete(); exp_u.delete(); exp_l.delete();
        hdr_seen.delete(); out_cyc.delete(); rdy_trace.delete();
        model_cnt = 0;
    endtask

    task automatic do_reset();
        in_tvalid  = 1'b0;
        in_tdata   = '0;
        in_tlast   = 1'b0;
        out_tready = 1'b1;
        areset     = 1'b1;
        repeat (2) @(negedge clk);
        areset = 1'b0;
        clear_model();
    endtask

    // Drives inputs on the falling edge, samples 1 ns later (well before the rising edge),
    // and scores the handshakes that the coming rising edge will complete.
    task automatic run(input int stall_pct, input int gap_pct, input int max_in, input int budget);
        bit            holding = 1'b0;
        bit            prev_stall = 1'b0;
        logic [BW-1:0] prev_d = '0;
        bit            prev_u = 1'b0;
        bit            prev_l = 1'b0;
        int            consumed = 0;
        int            n = 0;
        first_in_cyc = -1;
        out_cyc.delete();
        rdy_trace.delete();
        cyc = 0;
        while (1) begin
            @(negedge clk);
            if (!holding) begin
                in_tvalid = (src_d.size() > 0) && ($urandom_range(99) >= gap_pct);
                in_tdata  = (src_d.size() > 0) ? src_d[0] : '0;
                in_tlast  = (src_l.size() > 0) ? src_l[0] : 1'b0;
            end
            out_tready = ($urandom_range(99) >= stall_pct);
            #1;
            if (prev_stall) begin
                check("stall_valid", BW'(out_tvalid), BW'(1));
                check("stall_data", out_tdata, prev_d);
                check("stall_flags", BW'({out_tuser, out_tlast}), BW'({prev_u, prev_l}));
            end
            if (in_tvalid) begin
                rdy_trace.push_back(in_tready);
                if (first_in_cyc < 0) first_in_cyc = cyc;
            end
            if (in_tvalid && in_tready) begin
                void'(src_d.pop_front());
                void'(src_l.pop_front());
                consumed++;
            end
            holding = in_tvalid && !in_tready;
            if (out_tvalid && out_tready) begin
                out_cyc.push_back(cyc);
                if (out_tuser) hdr_seen.push_back(out_tdata);
                if (exp_d.size() == 0) begin
                    check("extra_word", out_tdata, '1 ^ out_tdata);
                end else begin
                    check("out_data", out_tdata, exp_d.pop_front());
                    check("out_tuser", BW'(out_tuser), BW'(exp_u.pop_front()));
                    check("out_tlast", BW'(out_tlast), BW'(exp_l.pop_front()));
                end
            end
            prev_stall = out_tvalid && !out_tready;
            prev_d = out_tdata;
            prev_u = out_tuser;
            prev_l = out_tlast;
            cyc++;
            n++;
            if (max_in > 0 && consumed >= max_in) break;
            if (max_in == 0 && exp_d.size() == 0 && src_d.size() == 0) break;
            if (n >= budget) begin
                check("timeout_pending", BW'(exp_d.size()), BW'(0));
                break;
            end
        end
        @(negedge clk);
        in_tvalid = 1'b0;
        in_tlast  = 1'b0;
    endtask

    initial begin
        int nb;
        do_reset();

        // Reset state, sampled away from the clock edge.
        out_tready = 1'b1;
        #1;
        check("rst_tvalid", BW'(out_tvalid), BW'(0));
        check("rst_tdata", out_tdata, '0);
        check("rst_tlast", BW'(out_tlast), BW'(0));
        check("rst_tuser", BW'(out_tuser), BW'(0));
        check("rst_in_tready", BW'(in_tready), BW'(0));

        // One 3-word frame, full throughput.
        add_frame(3);
        run(0, 0, 0, 100);
        check("hdr0_const", hdr_seen[0], 64'h006F_0002_0004_0004);
        check("out_count1", BW'(out_cyc.size()), BW'(4));
        check("latency", BW'(out_cyc[0]), BW'(first_in_cyc + 1));
        check("consecutive1", BW'(out_cyc[3] - out_cyc[0]), BW'(3));
        check("rdy_trace1", BW'({rdy_trace[0], rdy_trace[1], rdy_trace[2], rdy_trace[3]}), BW'(4'b0111));

        // Two back-to-back frames: exactly one in_tready bubble between them.
        do_reset();
        add_frame(3);
        add_frame(3);
        run(0, 0, 0, 100);
        check("hdr1_const", hdr_seen[1], 64'h026F_0002_0004_0004);
        check("out_count2", BW'(out_cyc.size()), BW'(8));
        check("consecutive2", BW'(out_cyc[7] - out_cyc[0]), BW'(7));
        nb = 0;
        foreach (rdy_trace[i]) if (!rdy_trace[i]) nb++;
        check("bubbles2", BW'(nb), BW'(2));
        check("bubble_pos", BW'(rdy_trace[4]), BW'(0));

        // Random stalls and gaps over 20 frames of 1..50 words.
        do_reset();
        for (int f = 0; f < 20; f++) add_frame($urandom_range(50, 1));
        run(50, 30, 0, 20000);
        check("hdr_count_rand", BW'(hdr_seen.size()), BW'(20));

        // 129 single-word frames: sequence number wraps after 127.
        do_reset();
        for (int f = 0; f < 129; f++) add_frame(1);
        run(20, 10, 0, 5000);
        check("hdr_count_wrap", BW'(hdr_seen.size()), BW'(129));
        check("hdr128_const", hdr_seen[127], 64'hFE6F_0002_0004_0004);
        check("hdr129_cnt", BW'(hdr_seen[128][63:57]), BW'(0));

        // Reset pulse after two payload words of frame 5.
        do_reset();
        for (int f = 0; f < 4; f++) add_frame($urandom_range(6, 1));
        run(0, 0, 0, 500);
        add_frame(5);
        run(0, 0, 2, 100);
        @(posedge clk);
        #3;
        areset = 1'b1;
        #1;
        check("amid_tvalid", BW'(out_tvalid), BW'(0));
        check("amid_tlast", BW'(out_tlast), BW'(0));
        check("amid_tuser", BW'(out_tuser), BW'(0));
        @(negedge clk);
        areset = 1'b0;
        clear_model();
        add_frame(4);
        run(30, 20, 0, 500);
        check("post_rst_hdrs", BW'(hdr_seen.size()), BW'(1));
        check("post_rst_cnt", BW'(hdr_seen[0][63:57]), BW'(0));

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
